// File: rtl/tlb_refill_ctrl.sv
// Miss/refill and flush sequencer for a small fully-associative TLB.
// Owns the per-entry valid bits, victim choice, walker handshake and flush sweep.
module tlb_refill_ctrl #(
    parameter  int ENTRIES = 8,
    localparam int IDXW    = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               lookup_valid_i,
    input  logic               lookup_hit_i,
    input  logic [IDXW-1:0]    lookup_hit_idx_i,
    input  logic               flush_i,
    output logic               ptw_req_valid_o,
    input  logic               ptw_req_ready_i,
    input  logic               ptw_resp_valid_i,
    input  logic               ptw_resp_error_i,
    output logic               fill_we_o,
    output logic [IDXW-1:0]    fill_idx_o,
    output logic               inval_we_o,
    output logic [IDXW-1:0]    inval_idx_o,
    output logic               plru_hit_o,
    output logic [IDXW-1:0]    plru_idx_o,
    input  logic [IDXW-1:0]    plru_repl_idx_i,
    output logic [ENTRIES-1:0] valid_o,
    output logic               busy_o,
    output logic               flush_done_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FLUSH} state_t;

    state_t              state, state_nxt;
    logic [ENTRIES-1:0]  valid, valid_nxt;
    logic [IDXW-1:0]     victim, victim_nxt;
    logic [IDXW-1:0]     cnt, cnt_nxt;
    logic                pend, pend_nxt;
    logic [IDXW-1:0]     free_idx;
    logic                free_found;

    // Downward scan so the last hit kept is the lowest invalid index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            valid  <= '0;
            victim <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
        end else begin
            state  <= state_nxt;
            valid  <= valid_nxt;
            victim <= victim_nxt;
            cnt    <= cnt_nxt;
            pend   <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        valid_nxt       = valid;
        victim_nxt      = victim;
        cnt_nxt         = cnt;
        pend_nxt        = pend;
        ptw_req_valid_o = 1'b0;
        fill_we_o       = 1'b0;
        fill_idx_o      = '0;
        inval_we_o      = 1'b0;
        inval_idx_o     = '0;
        plru_hit_o      = 1'b0;
        plru_idx_o      = '0;
        flush_done_o    = 1'b0;

        case (state)
            IDLE: begin
                if (lookup_valid_i && lookup_hit_i) begin
                    plru_hit_o = 1'b1;
                    plru_idx_o = lookup_hit_idx_i;
                end
                // A flush wins over a simultaneous miss; the requester retries the miss.
                if (flush_i) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end else if (lookup_valid_i && !lookup_hit_i) begin
                    victim_nxt = free_found ? free_idx : plru_repl_idx_i;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                ptw_req_valid_o = 1'b1;
                if (flush_i) pend_nxt = 1'b1;
                if (ptw_req_ready_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (flush_i) pend_nxt = 1'b1;
                if (ptw_resp_valid_i) begin
                    if (!ptw_resp_error_i) begin
                        state_nxt = FILL;
                    end else if (pend || flush_i) begin
                        state_nxt = FLUSH;
                        pend_nxt  = 1'b0;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FILL: begin
                fill_we_o         = 1'b1;
                fill_idx_o        = victim;
                plru_hit_o        = 1'b1;
                plru_idx_o        = victim;
                valid_nxt[victim] = 1'b1;
                // A flush seen in this very cycle must not be lost on the way out.
                if (pend || flush_i) begin
                    state_nxt = FLUSH;
                    pend_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                inval_we_o     = 1'b1;
                inval_idx_o    = cnt;
                valid_nxt[cnt] = 1'b0;
                if (cnt == IDXW'(ENTRIES - 1)) begin
                    flush_done_o = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + IDXW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign valid_o = valid;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Randomised and directed bench for tlb_refill_ctrl against a transaction-level model.
`timescale 1ns/1ps
module tb_tlb_refill_ctrl;

    localparam int ENTRIES = 8;
    localparam int IDXW    = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic               lv, hit, flush, ready, resp_valid, resp_err;
    logic [IDXW-1:0]    hidx, plru;
    logic               ptw_req, fill_we, inval_we, plru_hit, busy, flush_done;
    logic [IDXW-1:0]    fill_idx, inval_idx, plru_idx;
    logic [ENTRIES-1:0] valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: a walk in flight, whether its request was accepted, whether the
    // write-back cycle is now, and how many flush beats remain.
    bit [ENTRIES-1:0] mv;
    bit               walk, req_acc, fill_now, fl_pend;
    int               fl_left, m_victim;

    always #5 clk = ~clk;

    tlb_refill_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_valid_i(lv), .lookup_hit_i(hit), .lookup_hit_idx_i(hidx),
        .flush_i(flush),
        .ptw_req_valid_o(ptw_req), .ptw_req_ready_i(ready),
        .ptw_resp_valid_i(resp_valid), .ptw_resp_error_i(resp_err),
        .fill_we_o(fill_we), .fill_idx_o(fill_idx),
        .inval_we_o(inval_we), .inval_idx_o(inval_idx),
        .plru_hit_o(plru_hit), .plru_idx_o(plru_idx),
        .plru_repl_idx_i(plru),
        .valid_o(valid), .busy_o(busy), .flush_done_o(flush_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mv = '0; walk = 0; req_acc = 0; fill_now = 0; fl_pend = 0; fl_left = 0; m_victim = 0;
    endtask

    function automatic int pick_victim();
        for (int i = 0; i < ENTRIES; i++)
            if (!mv[i]) return i;
        return int'(plru);
    endfunction

    task automatic model_compare();
        bit flushing, busy_e, ph_e;
        int pidx_e;
        flushing = (fl_left > 0);
        busy_e   = walk || flushing;
        ph_e     = fill_now || (!busy_e && lv && hit);
        pidx_e   = fill_now ? m_victim : ((!busy_e && lv && hit) ? int'(hidx) : 0);
        chk("m_valid",     valid,      mv);
        chk("m_busy",      busy,       busy_e);
        chk("m_req",       ptw_req,    walk && !req_acc && !fill_now);
        chk("m_fill_we",   fill_we,    fill_now);
        chk("m_fill_idx",  fill_idx,   fill_now ? m_victim : 0);
        chk("m_inval_we",  inval_we,   flushing);
        chk("m_inval_idx", inval_idx,  flushing ? ENTRIES - fl_left : 0);
        chk("m_plru_hit",  plru_hit,   ph_e);
        chk("m_plru_idx",  plru_idx,   pidx_e);
        chk("m_done",      flush_done, fl_left == 1);
    endtask

    task automatic model_update();
        bit pend_now;
        pend_now = fl_pend || flush;
        if (fl_left > 0) begin
            mv[ENTRIES - fl_left] = 1'b0;
            fl_left--;
        end else if (fill_now) begin
            mv[m_victim] = 1'b1;
            fill_now = 0; walk = 0;
            if (pend_now) begin fl_left = ENTRIES; fl_pend = 0; end
        end else if (walk) begin
            if (flush) fl_pend = 1;
            if (!req_acc) begin
                if (ready) req_acc = 1;
            end else if (resp_valid) begin
                if (resp_err) begin
                    walk = 0;
                    if (pend_now) begin fl_left = ENTRIES; fl_pend = 0; end
                end else begin
                    fill_now = 1;
                end
            end
        end else if (flush) begin
            fl_left = ENTRIES;
        end else if (lv && !hit) begin
            walk = 1; req_acc = 0; m_victim = pick_victim();
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
    task automatic step();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        if (rstn) model_update();
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic idle_inputs();
        lv = 0; hit = 0; hidx = '0; flush = 0; ready = 0; resp_valid = 0; resp_err = 0;
    endtask

    task automatic miss_walk(input logic [IDXW-1:0] p, input int exp_idx);
        lv = 1; hit = 0; plru = p;
        step();
        lv = 0; ready = 1;
        step();
        ready = 0; resp_valid = 1;
        step();
        resp_valid = 0;
        probe();
        chk("fill_idx", fill_idx, exp_idx);
        step();
    endtask

    initial begin
        rstn = 0; plru = '0;
        idle_inputs();
        model_reset();
        step(); step();
        rstn = 1;
        probe();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", ptw_req, 0);
        chk("rst_done", flush_done, 0);

        // First miss into an empty array, request held while ready stays low.
        lv = 1; hit = 0; plru = 3'd3;
        step();
        lv = 0;
        probe();
        chk("req_at_n1", ptw_req, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            probe();
            chk("req_held", ptw_req, 1);
        end
        ready = 1;
        step();
        ready = 0; resp_valid = 1;
        probe();
        chk("req_dropped", ptw_req, 0);
        step();
        resp_valid = 0;
        probe();
        chk("fill_we", fill_we, 1);
        chk("fill_idx0", fill_idx, 0);
        chk("plru_idx0", plru_idx, 0);
        step();
        probe();
        chk("valid_01", valid, 8'h01);

        // Lowest invalid entry wins over PLRU until the array is full.
        miss_walk(3'd3, 1);
        miss_walk(3'd3, 2);
        miss_walk(3'd5, 3);
        for (int i = 4; i < ENTRIES; i++) miss_walk(3'd5, i);
        probe();
        chk("valid_ff", valid, 8'hFF);
        miss_walk(3'd5, 5);

        // Hit reporting: live in IDLE, suppressed while a walk is waiting.
        lv = 1; hit = 1; hidx = 3'd6;
        probe();
        chk("idle_hit", plru_hit, 1);
        chk("idle_hit_idx", plru_idx, 6);
        chk("idle_hit_busy", busy, 0);
        step();
        hit = 0; plru = 3'd2;
        step();
        lv = 0; ready = 1;
        step();
        ready = 0; lv = 1; hit = 1; hidx = 3'd6;
        probe();
        chk("wait_hit", plru_hit, 0);
        step();
        idle_inputs();

        // Faulted walk: no fill, straight back to IDLE.
        resp_valid = 1; resp_err = 1;
        step();
        idle_inputs();
        probe();
        chk("err_no_fill", fill_we, 0);
        chk("err_busy", busy, 0);
        chk("err_valid", valid, 8'hFF);

        // Flush raised mid-walk runs after the fill.
        lv = 1; plru = 3'd4;
        step();
        lv = 0; ready = 1;
        step();
        ready = 0; flush = 1;
        step();
        flush = 0; resp_valid = 1;
        step();
        resp_valid = 0;
        probe();
        chk("pend_fill", fill_we, 1);
        step();
        for (int i = 0; i < ENTRIES; i++) begin
            probe();
            chk("fl_we", inval_we, 1);
            chk("fl_idx", inval_idx, i);
            chk("fl_done", flush_done, i == ENTRIES - 1);
            step();
        end
        probe();
        chk("fl_valid0", valid, 0);
        chk("fl_idle", busy, 0);

        // Flush beats a simultaneous miss; then reset lands in the middle of the sweep.
        lv = 1; hit = 0; flush = 1;
        step();
        idle_inputs();
        probe();
        chk("fm_no_req", ptw_req, 0);
        chk("fm_inval", inval_we, 1);
        step(); step(); step();
        probe();
        chk("fl_at3", inval_idx, 3);
        rstn = 0;
        #0.5;
        model_reset();
        chk("ar_inval", inval_we, 0);
        chk("ar_idx", inval_idx, 0);
        chk("ar_busy", busy, 0);
        chk("ar_valid", valid, 0);
        chk("ar_done", flush_done, 0);
        step();
        rstn = 1;

        // Random traffic checked cycle-by-cycle against the model.
        for (int c = 0; c < 2500; c++) begin
            lv         = ($urandom % 3) == 0;
            hit        = $urandom % 2;
            hidx       = IDXW'($urandom);
            flush      = ($urandom % 40) == 0;
            ready      = $urandom % 2;
            resp_valid = ($urandom % 3) == 0;
            resp_err   = ($urandom % 4) == 0;
            plru       = IDXW'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_refill_ctrl.md
Name: tlb_refill_ctrl

Overview:
- Miss/refill and flush sequencer for a small fully-associative translation array (TLB).
- Tracks per-entry valid bits and selects victims: the lowest-index invalid entry, otherwise the index supplied by the external PLRU.
- Runs the request/response handshake with the page-table walker and issues fill and invalidate write strobes to the array.
- Drives the PLRU update port on lookup hits and on fills.

Parameters:
- ENTRIES, 8, number of TLB entries; power of two, ≥2.
- IDXW, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- lookup_valid_i  in  1  a lookup result is presented this cycle
- lookup_hit_i  in  1  lookup hit in the array
- lookup_hit_idx_i  in  IDXW  index of the hit entry
- flush_i  in  1  invalidate-all request (level, sampled per cycle)
- ptw_req_valid_o  out  1  walk request to the page-table walker
- ptw_req_ready_i  in  1  walker accepts the request
- ptw_resp_valid_i  in  1  walker response strobe
- ptw_resp_error_i  in  1  walk faulted; no fill (qualified by resp_valid)
- fill_we_o  out  1  write the walker result into the array
- fill_idx_o  out  IDXW  victim index for the fill
- inval_we_o  out  1  clear one array entry
- inval_idx_o  out  IDXW  entry being cleared
- plru_hit_o  out  1  PLRU update strobe
- plru_idx_o  out  IDXW  entry to mark most-recently-used
- plru_repl_idx_i  in  IDXW  current PLRU replacement candidate
- valid_o  out  ENTRIES  per-entry valid bits
- busy_o  out  1  controller not IDLE; requester stalls lookups
- flush_done_o  out  1  one-cycle pulse on the final invalidate

Behaviour:
- Reset: state=IDLE; valid_o=0, victim=0, flush counter=0, flush_pend=0. All outputs 0.
- States: IDLE, REQ, WAIT, FILL, FLUSH. busy_o = (state != IDLE).
- IDLE:
  - lookup_valid_i & lookup_hit_i: plru_hit_o=1 and plru_idx_o=lookup_hit_idx_i in the same cycle (combinational). No state change.
  - flush_i: go to FLUSH with counter=0. Flush beats a simultaneous miss; the miss is dropped and the requester retries.
  - Otherwise, lookup_valid_i & !lookup_hit_i: latch the victim and go to REQ.
- Victim selection: the lowest index i with valid_o[i]=0; if all entries are valid, plru_repl_idx_i. Sampled only in the miss cycle.
- REQ: ptw_req_valid_o=1, held until ptw_req_ready_i; ptw_req_valid_o never drops before acceptance. Acceptance moves to WAIT. Miss cycle N gives ptw_req_valid_o at N+1.
- WAIT: wait for ptw_resp_valid_i.
  - With error: go to FLUSH if flush_pend, else IDLE. No fill, no PLRU update.
  - Without error: go to FILL.
- FILL, one cycle:
  - fill_we_o=1, fill_idx_o=victim.
  - plru_hit_o=1, plru_idx_o=victim.
  - valid_o[victim] set at the clock edge.
  - Next state is FLUSH if flush_pend, else IDLE.
- flush_pend: set by flush_i in REQ/WAIT/FILL; cleared on entry to FLUSH. An in-flight walk always completes its handshake, then the flush runs.
- FLUSH: one entry per cycle.
  - inval_we_o=1, inval_idx_o=counter; valid_o[counter] cleared at the edge; counter increments.
  - On counter=ENTRIES-1: flush_done_o=1 in that cycle, then IDLE with counter=0.
  - Duration is exactly ENTRIES cycles. flush_i during FLUSH is absorbed and does not restart the walk.
- Lookup inputs are ignored outside IDLE, so plru_hit_o is driven only by IDLE hits or FILL.
- fill_idx_o/inval_idx_o are don't-care when their strobe is 0; drive them 0.
- ptw_resp_valid_i outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to the reset state, including valid_o=0. A pending walker handshake is abandoned.

Test Plan:
- ENTRIES=8. Reset, miss at idx-free array → victim 0; ptw_req_valid_o at +1 cycle; hold ready=0 for 3 cycles (valid stays 1); response ok → fill_we_o, fill_idx_o=0, plru_idx_o=0, valid_o=8'h01.
- valid_o=8'hFF, plru_repl_idx_i=5, miss → fill_idx_o=5. Then valid_o=8'hF7 → next miss victim 3, regardless of the PLRU value.
- IDLE hit at idx 6 → plru_hit_o=1, plru_idx_o=6 in the same cycle, busy_o=0. The same hit in WAIT → plru_hit_o=0.
- Response with ptw_resp_error_i=1 → no fill_we_o, valid_o unchanged, back to IDLE, busy_o=0 the next cycle.
- flush_i during WAIT → fill completes (valid bit set), then 8 invalidate cycles idx 0..7, flush_done_o on idx 7, valid_o=0, IDLE.
- flush_i and a miss in the same IDLE cycle → FLUSH, no ptw_req_valid_o. Reset asserted in FLUSH at idx 3 → all outputs 0 and IDLE immediately.
